// File: rtl/minhash_sched_if.sv
// rtl/minhash_sched_if.sv - k-mer in, shared-hasher, seed-config and signature-out signal bundle
interface minhash_sched_if #(
    parameter int HASHER_DATA_BITS = 32,
    parameter int NUM_HASHES       = 4,
    parameter int IDX_BITS         = $clog2(NUM_HASHES)
);
    logic                        kmer_valid;
    logic                        kmer_ready;
    logic [HASHER_DATA_BITS-1:0] kmer_data;
    logic                        kmer_last;

    logic [HASHER_DATA_BITS-1:0] hasher_seed;
    logic [HASHER_DATA_BITS-1:0] hasher_kmer;
    logic [HASHER_DATA_BITS-1:0] hasher_signature;

    logic                        cfg_we;
    logic [IDX_BITS-1:0]         cfg_addr;
    logic [HASHER_DATA_BITS-1:0] cfg_seed;

    logic                        sig_valid;
    logic                        sig_ready;
    logic [IDX_BITS-1:0]         sig_idx;
    logic [HASHER_DATA_BITS-1:0] sig_data;
    logic                        sig_last;

    logic                        busy;

    modport slave (
        input  kmer_valid, kmer_data, kmer_last, hasher_signature,
               cfg_we, cfg_addr, cfg_seed, sig_ready,
        output kmer_ready, hasher_seed, hasher_kmer,
               sig_valid, sig_idx, sig_data, sig_last, busy
    );

    modport master (
        output kmer_valid, kmer_data, kmer_last, hasher_signature,
               cfg_we, cfg_addr, cfg_seed, sig_ready,
        input  kmer_ready, hasher_seed, hasher_kmer,
               sig_valid, sig_idx, sig_data, sig_last, busy
    );
endinterface

// File: rtl/minhash_sched.sv
// rtl/minhash_sched.sv - time-multiplexes one external hasher over all seeds to build MinHash signatures
module minhash_sched #(
    parameter int                          HASHER_DATA_BITS = 32,
    parameter int                          NUM_HASHES       = 4,
    parameter int                          IDX_BITS         = $clog2(NUM_HASHES),
    parameter logic [HASHER_DATA_BITS-1:0] SEED_BASE        = 32'hac718add
) (
    input  logic            clk,
    input  logic            rst_n,
    minhash_sched_if.slave  bus
);
    localparam int                  HDB      = HASHER_DATA_BITS;
    localparam logic [IDX_BITS-1:0] LAST_IDX = IDX_BITS'(NUM_HASHES - 1);

    typedef enum logic [1:0] {IDLE, HASH, DRAIN} state_t;

    state_t              state;
    logic [IDX_BITS-1:0] idx;
    logic [HDB-1:0]      kmer_q;
    logic                last_q;
    logic [HDB-1:0]      seed [NUM_HASHES];
    logic [HDB-1:0]      mins [NUM_HASHES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            idx    <= '0;
            kmer_q <= '0;
            last_q <= 1'b0;
            for (int i = 0; i < NUM_HASHES; i++) begin
                mins[i] <= '1;
                seed[i] <= SEED_BASE ^ HDB'(32'(i) * 32'h9E3779B9);
            end
        end else begin
            // Decoding each entry drops out-of-range addresses without a range compare.
            if (state == IDLE && bus.cfg_we) begin
                for (int i = 0; i < NUM_HASHES; i++) begin
                    if (bus.cfg_addr == IDX_BITS'(i)) seed[i] <= bus.cfg_seed;
                end
            end
            case (state)
                IDLE: begin
                    if (bus.kmer_valid) begin
                        kmer_q <= bus.kmer_data;
                        last_q <= bus.kmer_last;
                        idx    <= '0;
                        state  <= HASH;
                    end
                end
                HASH: begin
                    if (bus.hasher_signature < mins[idx]) mins[idx] <= bus.hasher_signature;
                    if (idx == LAST_IDX) begin
                        idx   <= '0;
                        state <= last_q ? DRAIN : IDLE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DRAIN: begin
                    if (bus.sig_ready) begin
                        if (idx == LAST_IDX) begin
                            for (int i = 0; i < NUM_HASHES; i++) mins[i] <= '1;
                            idx   <= '0;
                            state <= IDLE;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // The hasher is always fed; its result only matters in HASH.
    assign bus.hasher_seed = seed[idx];
    assign bus.hasher_kmer = kmer_q;

    assign bus.kmer_ready = (state == IDLE);
    assign bus.busy       = (state != IDLE);
    assign bus.sig_valid  = (state == DRAIN);
    assign bus.sig_idx    = (state == DRAIN) ? idx : '0;
    assign bus.sig_data   = (state == DRAIN) ? mins[idx] : '0;
    assign bus.sig_last   = (state == DRAIN) && (idx == LAST_IDX);
endmodule

// File: tb/tb_minhash_sched.sv
// tb/tb_minhash_sched.sv - randomized directed bench for minhash_sched with a MinHash reference model
module tb_minhash_sched;
    localparam int NH = 4;
    localparam int IB = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    minhash_sched_if #(.HASHER_DATA_BITS(32), .NUM_HASHES(NH), .IDX_BITS(IB)) bus ();

    minhash_sched #(.HASHER_DATA_BITS(32), .NUM_HASHES(NH), .IDX_BITS(IB)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    function automatic logic [31:0] murmur(input logic [31:0] seed, input logic [31:0] k);
        logic [31:0] kk;
        logic [31:0] h;
        kk = k * 32'hcc9e2d51;
        kk = {kk[16:0], kk[31:17]};
        kk = kk * 32'h1b873593;
        h  = seed ^ kk;
        h  = {h[18:0], h[31:19]};
        h  = h * 32'd5 + 32'he6546b64;
        h  = h ^ 32'd4;
        h  = h ^ (h >> 16);
        h  = h * 32'h85ebca6b;
        h  = h ^ (h >> 13);
        h  = h * 32'hc2b2ae35;
        h  = h ^ (h >> 16);
        return h;
    endfunction

    assign bus.hasher_signature = murmur(bus.hasher_seed, bus.hasher_kmer);

    int          checks = 0;
    int          failures = 0;
    logic [31:0] mseed [NH];
    logic [31:0] set_q [$];
    logic [31:0] obs_sig [NH];
    logic [31:0] t2_exp [NH];
    logic [31:0] r;

    function automatic logic [31:0] def_seed(input int i);
        logic [31:0] m;
        m = 32'(i) * 32'h9E3779B9;
        return 32'hac718add ^ m;
    endfunction

    function automatic logic [31:0] model_min(input int i);
        logic [31:0] m;
        m = 32'hffffffff;
        foreach (set_q[j]) begin
            if (murmur(mseed[i], set_q[j]) < m) m = murmur(mseed[i], set_q[j]);
        end
        return m;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic reset_model;
        for (int i = 0; i < NH; i++) mseed[i] = def_seed(i);
        set_q.delete();
    endtask

    task automatic send_kmer(input logic [31:0] k, input bit last, input bit poke_cfg);
        int n;
        n = 0;
        bus.kmer_valid = 1'b1;
        bus.kmer_data  = k;
        bus.kmer_last  = last;
        while (!bus.kmer_ready && n < 20) begin
            tick;
            n++;
        end
        chk("accept_wait", 32'(n < 20), 32'd1);
        tick;
        bus.kmer_valid = 1'b0;
        bus.kmer_last  = 1'b0;
        bus.cfg_we     = 1'b0;
        set_q.push_back(k);
        for (int j = 0; j < NH; j++) begin
            chk("hash_kmer", bus.hasher_kmer, k);
            chk("hash_seed", bus.hasher_seed, mseed[j]);
            chk("hash_kready", 32'(bus.kmer_ready), 32'd0);
            chk("hash_busy", 32'(bus.busy), 32'd1);
            if (poke_cfg && j == 1) begin
                bus.cfg_we   = 1'b1;
                bus.cfg_addr = IB'(j + 1);
                bus.cfg_seed = $urandom;
            end
            tick;
            bus.cfg_we = 1'b0;
        end
    endtask

    task automatic drain(input int stall_idx);
        logic [31:0] exp [NH];
        int n;
        for (int i = 0; i < NH; i++) exp[i] = model_min(i);
        for (int w = 0; w < NH; w++) begin
            n = 0;
            while (!bus.sig_valid && n < 20) begin
                tick;
                n++;
            end
            chk("sig_wait", 32'(n < 20), 32'd1);
            chk("sig_idx", 32'(bus.sig_idx), 32'(w));
            chk("sig_data", bus.sig_data, exp[w]);
            chk("sig_last", 32'(bus.sig_last), 32'(w == NH - 1));
            chk("drain_kready", 32'(bus.kmer_ready), 32'd0);
            obs_sig[w] = bus.sig_data;
            if (w == stall_idx) begin
                bus.sig_ready  = 1'b0;
                bus.kmer_valid = 1'b1;
                bus.kmer_data  = $urandom;
                for (int s = 0; s < 5; s++) begin
                    tick;
                    chk("stall_valid", 32'(bus.sig_valid), 32'd1);
                    chk("stall_idx", 32'(bus.sig_idx), 32'(w));
                    chk("stall_data", bus.sig_data, exp[w]);
                    chk("stall_kready", 32'(bus.kmer_ready), 32'd0);
                end
                bus.sig_ready  = 1'b1;
                bus.kmer_valid = 1'b0;
            end
            tick;
        end
        chk("post_valid", 32'(bus.sig_valid), 32'd0);
        chk("post_data", bus.sig_data, 32'd0);
        chk("post_busy", 32'(bus.busy), 32'd0);
        chk("post_kready", 32'(bus.kmer_ready), 32'd1);
        set_q.delete();
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        int nk;
        bus.kmer_valid = 1'b0;
        bus.kmer_data  = '0;
        bus.kmer_last  = 1'b0;
        bus.cfg_we     = 1'b0;
        bus.cfg_addr   = '0;
        bus.cfg_seed   = '0;
        bus.sig_ready  = 1'b1;
        reset_model();

        // Reset state
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        tick;
        chk("rst_kready", 32'(bus.kmer_ready), 32'd1);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_valid", 32'(bus.sig_valid), 32'd0);
        chk("rst_data", bus.sig_data, 32'd0);
        chk("rst_idx", 32'(bus.sig_idx), 32'd0);
        chk("rst_last", 32'(bus.sig_last), 32'd0);
        chk("rst_seed0", bus.hasher_seed, 32'hac718add);
        chk("rst_hkmer", bus.hasher_kmer, 32'd0);

        // Single-kmer set
        send_kmer(32'hab1020c5, 1'b1, 1'b0);
        drain(-1);
        for (int i = 0; i < NH; i++) t2_exp[i] = murmur(def_seed(i), 32'hab1020c5);
        for (int i = 0; i < NH; i++) chk("t2_direct", obs_sig[i], t2_exp[i]);

        // Min tracking across a fixed set and a repeated k-mer
        send_kmer(32'hab1020c5, 1'b0, 1'b0);
        send_kmer(32'h00000000, 1'b0, 1'b0);
        send_kmer(32'hffffffff, 1'b1, 1'b0);
        drain(-1);
        r = $urandom;
        send_kmer(r, 1'b0, 1'b0);
        send_kmer(r, 1'b1, 1'b0);
        drain(-1);

        // Random sets, one with back-pressure at index 1
        for (int s = 0; s < 5; s++) begin
            nk = $urandom_range(1, 4);
            for (int k = 0; k < nk; k++) send_kmer($urandom, k == nk - 1, 1'b0);
            drain(s == 1 ? 1 : -1);
        end

        // Seed config in IDLE, write during HASH dropped, write coincident with accept
        bus.cfg_we   = 1'b1;
        bus.cfg_addr = IB'(2);
        bus.cfg_seed = 32'd0;
        tick;
        bus.cfg_we = 1'b0;
        mseed[2] = 32'd0;
        send_kmer($urandom, 1'b0, 1'b1);
        send_kmer($urandom, 1'b1, 1'b1);
        drain(-1);
        r = $urandom;
        bus.cfg_we   = 1'b1;
        bus.cfg_addr = IB'(0);
        bus.cfg_seed = r;
        mseed[0] = r;
        send_kmer($urandom, 1'b1, 1'b0);
        drain(-1);

        // Reset in the middle of hashing a last k-mer
        bus.kmer_valid = 1'b1;
        bus.kmer_data  = 32'h12345678;
        bus.kmer_last  = 1'b1;
        tick;
        bus.kmer_valid = 1'b0;
        bus.kmer_last  = 1'b0;
        tick;
        tick;
        chk("mid_busy", 32'(bus.busy), 32'd1);
        rst_n = 1'b0;
        #2;
        chk("arst_kready", 32'(bus.kmer_ready), 32'd1);
        chk("arst_busy", 32'(bus.busy), 32'd0);
        tick;
        rst_n = 1'b1;
        reset_model();
        for (int c = 0; c < 3; c++) begin
            tick;
            chk("arst_novalid", 32'(bus.sig_valid), 32'd0);
        end
        chk("arst_seed0", bus.hasher_seed, 32'hac718add);
        send_kmer(32'hab1020c5, 1'b1, 1'b0);
        drain(-1);
        for (int i = 0; i < NH; i++) chk("t6_vs_t2", obs_sig[i], t2_exp[i]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
